mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multi-cycle main control FSM for the MIPS core. It sequences instruction fetch, decode, execute, memory and write-back over several clock cycles, so that one ALU and one memory port are shared across all steps. Each state drives the datapath control word, including the 2-bit `ALUOp` consumed by the ALU control decoder. It stalls on a memory-ready handshake and flags illegal opcodes.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: standard multi-cycle datapath controls.
- `branch_ne` out 1: inverts the Zero condition for `PCWriteCond` (bne).
- `ALUOp` out 2: 00 add (lw/sw/address), 01 sub (branch compare), 10 R-format (funct decoded downstream), 11 I-type ALU.
- `ALUSrcB` out 2: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `retire` out 1: one-cycle pulse on instruction completion.
- `illegal_op` out 1: one-cycle pulse on an unknown opcode.
- `state` out 4: current state (debug).

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, IEX 9, IWB 10, JUMP 11. Encodings 12–15 are unreachable and recover to FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite` and `PCWrite` assert only while `mem_ready`=1. Go to DECODE when `mem_ready`=1, otherwise hold.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Dispatch on opcode:
  - lw 0x23 / sw 0x2B → MEMADR
  - R 0x00 → REX
  - beq 0x04 / bne 0x05 → BRANCH
  - addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, slti 0x0A → IEX
  - j 0x02 → JUMP
  - anything else → FETCH, with `illegal_op` pulsed in this cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Go to MEMRD for lw, MEMWR for sw; the opcode is latched from IR, which is stable.
- MEMRD: `MemRead`=1, `IorD`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `retire`=1. Go to FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Hold until `mem_ready`; `retire` is asserted in the cycle `mem_ready`=1, then go to FETCH.
- REX: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Go to RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `retire`=1. Go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, `branch_ne`=(opcode==0x05), `retire`=1. Go to FETCH.
- IEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11. Go to IWB.
- IWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `retire`=1. Go to FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10, `retire`=1. Go to FETCH.
- Outputs not listed for a state are 0; ALU-related outputs default to 00/0.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational (Moore) from the state; `PCWrite`, `IRWrite` and `retire` are additionally gated by `mem_ready` in FETCH and MEMWR.
- While `rst`=1: state=FETCH and every output is forced to 0, so there are no memory strobes during reset. `state` reads 0.
- After `rst` deasserts, FETCH is active in the first cycle.
- Latency with `mem_ready` held at 1:
  - lw 5 cycles
  - sw, R, I-type 4 cycles
  - beq/bne, j 3 cycles
  - illegal opcode 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe other than the held `MemRead`/`MemWrite` fires during a stall.
- `rst` asserted mid-instruction aborts it immediately; no `retire` pulse is produced.
- `retire` and `illegal_op` are never asserted together.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - state encoding localparams
  - ALUOp constants (00/01/10/11)
  - ALUSrcB and PCSource constants.

  The ALU control decoder imports the ALUOp constants from the same package.
- One sub-module, `mips_ctrl_decode`: purely combinational, mapping (state, opcode, mem_ready) to the control word. The top level holds only the state register and the next-state logic.

## Test plan
- Reset, then `opcode`=0x00 with `mem_ready`=1 → state sequence 0,1,6,7,0; `ALUOp`=10 in REX; `RegWrite`=`RegDst`=1 in RWB; one `retire`.
- lw (0x23) with `mem_ready` low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0; `MemRead`=`IorD`=1 held throughout MEMRD; 8 cycles total.
- bne (0x05) → sequence 0,1,8,0; in BRANCH `ALUOp`=01, `PCWriteCond`=1, `branch_ne`=1, `PCSource`=01.
- Opcode 0x3F → `illegal_op` pulses in DECODE, next state FETCH, no `retire`, no `RegWrite` or `MemWrite`.
- `rst` asserted during MEMWR with `mem_ready`=0 → `MemWrite` drops to 0 asynchronously; state=0; no `retire`.
- Back-to-back addi (0x08) then j (0x02) → `ALUOp`=11 and `ALUSrcB`=10 in IEX; `PCSource`=10 and `PCWrite`=1 in JUMP; 7 cycles; two `retire` pulses.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM and the
// ALU control decoder: opcodes, state encodings, mux-select constants.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] ALUSRCB_REG     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       branch_ne;
    logic       retire;
    logic       illegal_op;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctrl_t;

  // DECODE dispatch target; unknown opcodes return to FETCH.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                                 dispatch = S_MEMADR;
      OP_RTYPE:                                     dispatch = S_REX;
      OP_BEQ, OP_BNE:                               dispatch = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:   dispatch = S_IEX;
      OP_J:                                         dispatch = S_JUMP;
      default:                                      dispatch = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-word decode from (state, opcode, mem_ready).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control word; everything not named is 0.
  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALUSRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (dispatch(opcode) == S_FETCH);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.retire        = 1'b1;
      end
      S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state register, next-state logic and
// reset gating of the control word produced by mips_ctrl_decode.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       branch_ne,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_d;
  ctrl_t  ctrl;

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_d)
  );

  // State register, asynchronously reset to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_next;
  end

  // Next-state: memory states hold until mem_ready; encodings 12-15 recover to FETCH.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = dispatch(opcode);
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_REX:    state_next = S_RWB;
      S_IEX:    state_next = S_IWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Reset forces the whole word to 0 so FETCH drives no memory strobe during reset.
  always_comb begin
    ctrl = rst ? '0 : ctrl_d;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign branch_ne   = ctrl.branch_ne;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign retire      = ctrl.retire;
  assign illegal_op  = ctrl.illegal_op;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control: per-cycle vector table through a
// scoreboard queue, plus async-reset abort and back-to-back latency checks.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, branch_ne, retire, illegal_op;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .branch_ne(branch_ne), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .retire(retire),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Word layout: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  RegWrite,RegDst,ALUSrcA,branch_ne,retire,illegal_op, ALUOp, ALUSrcB, PCSource}
  localparam logic [18:0] W_ZERO   = 19'd0;
  localparam logic [18:0] W_FETCH1 = {13'b1001001000000, 2'b00, 2'b01, 2'b00};
  localparam logic [18:0] W_FETCH0 = {13'b0001000000000, 2'b00, 2'b01, 2'b00};
  localparam logic [18:0] W_DEC    = {13'b0000000000000, 2'b00, 2'b11, 2'b00};
  localparam logic [18:0] W_DECILL = {13'b0000000000001, 2'b00, 2'b11, 2'b00};
  localparam logic [18:0] W_MEMADR = {13'b0000000001000, 2'b00, 2'b10, 2'b00};
  localparam logic [18:0] W_MEMRD  = {13'b0011000000000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_MEMWB  = {13'b0000010100010, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_MEMWR0 = {13'b0010100000000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_MEMWR1 = {13'b0010100000010, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_REX    = {13'b0000000001000, 2'b10, 2'b00, 2'b00};
  localparam logic [18:0] W_RWB    = {13'b0000000110010, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_BNE    = {13'b0100000001110, 2'b01, 2'b00, 2'b01};
  localparam logic [18:0] W_BEQ    = {13'b0100000001010, 2'b01, 2'b00, 2'b01};
  localparam logic [18:0] W_IEX    = {13'b0000000001000, 2'b11, 2'b10, 2'b00};
  localparam logic [18:0] W_IWB    = {13'b0000000100010, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] W_JUMP   = {13'b1000000000010, 2'b00, 2'b00, 2'b10};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] word;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [18:0] actual_word();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            RegWrite, RegDst, ALUSrcA, branch_ne, retire, illegal_op,
            ALUOp, ALUSrcB, PCSource};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [18:0] w, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.st = st; v.word = w; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int cyc;
  int nret;

  initial begin
    // reset forces every output low even with mem_ready=1
    add(1, 6'h00, 1, 4'd0,  W_ZERO,   "reset");
    // R-type: 0,1,6,7
    add(0, 6'h00, 1, 4'd0,  W_FETCH1, "r_fetch");
    add(0, 6'h00, 1, 4'd1,  W_DEC,    "r_decode");
    add(0, 6'h00, 1, 4'd6,  W_REX,    "r_rex");
    add(0, 6'h00, 1, 4'd7,  W_RWB,    "r_rwb");
    // lw with 3 stall cycles in MEMRD: 0,1,2,3,3,3,3,4
    add(0, 6'h23, 1, 4'd0,  W_FETCH1, "lw_fetch");
    add(0, 6'h23, 1, 4'd1,  W_DEC,    "lw_decode");
    add(0, 6'h23, 1, 4'd2,  W_MEMADR, "lw_memadr");
    add(0, 6'h23, 0, 4'd3,  W_MEMRD,  "lw_memrd_stall1");
    add(0, 6'h23, 0, 4'd3,  W_MEMRD,  "lw_memrd_stall2");
    add(0, 6'h23, 0, 4'd3,  W_MEMRD,  "lw_memrd_stall3");
    add(0, 6'h23, 1, 4'd3,  W_MEMRD,  "lw_memrd_ready");
    add(0, 6'h23, 1, 4'd4,  W_MEMWB,  "lw_memwb");
    // bne: 0,1,8
    add(0, 6'h05, 1, 4'd0,  W_FETCH1, "bne_fetch");
    add(0, 6'h05, 1, 4'd1,  W_DEC,    "bne_decode");
    add(0, 6'h05, 1, 4'd8,  W_BNE,    "bne_branch");
    // illegal opcode: 0,1 then straight back to FETCH
    add(0, 6'h3F, 1, 4'd0,  W_FETCH1, "ill_fetch");
    add(0, 6'h3F, 1, 4'd1,  W_DECILL, "ill_decode");
    // sw with a FETCH stall and a MEMWR stall
    add(0, 6'h2B, 0, 4'd0,  W_FETCH0, "sw_fetch_stall");
    add(0, 6'h2B, 1, 4'd0,  W_FETCH1, "sw_fetch");
    add(0, 6'h2B, 1, 4'd1,  W_DEC,    "sw_decode");
    add(0, 6'h2B, 1, 4'd2,  W_MEMADR, "sw_memadr");
    add(0, 6'h2B, 0, 4'd5,  W_MEMWR0, "sw_memwr_stall");
    add(0, 6'h2B, 1, 4'd5,  W_MEMWR1, "sw_memwr_ready");
    // addi (mem_ready low outside memory states has no effect)
    add(0, 6'h08, 1, 4'd0,  W_FETCH1, "addi_fetch");
    add(0, 6'h08, 0, 4'd1,  W_DEC,    "addi_decode");
    add(0, 6'h08, 0, 4'd9,  W_IEX,    "addi_iex");
    add(0, 6'h08, 1, 4'd10, W_IWB,    "addi_iwb");
    // j
    add(0, 6'h02, 1, 4'd0,  W_FETCH1, "j_fetch");
    add(0, 6'h02, 1, 4'd1,  W_DEC,    "j_decode");
    add(0, 6'h02, 1, 4'd11, W_JUMP,   "j_jump");
    // beq, then back to FETCH
    add(0, 6'h04, 1, 4'd0,  W_FETCH1, "beq_fetch");
    add(0, 6'h04, 1, 4'd1,  W_DEC,    "beq_decode");
    add(0, 6'h04, 1, 4'd8,  W_BEQ,    "beq_branch");
    add(0, 6'h04, 1, 4'd0,  W_FETCH1, "final_fetch");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      sb.push_back(vecs[i]);
      @(negedge clk);
      begin
        vec_t e;
        e = sb.pop_front();
        check({e.name, "_state"}, 32'(state), 32'(e.st));
        check({e.name, "_ctrl"}, 32'(actual_word()), 32'(e.word));
      end
    end

    // rst during a stalled MEMWR aborts the store immediately
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #1;
    check("abort_pre_state", 32'(state), 32'd5);
    check("abort_pre_memwrite", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_retire", 32'(retire), 32'd0);
    check("abort_memread", 32'(MemRead), 32'd0);
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1; opcode = 6'h08;

    // back-to-back addi then j: two retires within 7 cycles
    cyc = 0;
    nret = 0;
    while (nret < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (retire === 1'b1) nret++;
      if (retire === 1'b1 && illegal_op === 1'b1) check("retire_illegal_overlap", 32'd1, 32'd0);
      if (nret < 2) begin
        @(posedge clk);
        #1 opcode = (cyc >= 4) ? 6'h02 : 6'h08;
      end
    end
    check("b2b_cycles", 32'(cyc), 32'd7);
    check("b2b_retires", 32'(nret), 32'd2);
    check("b2b_last_pcsource", 32'(PCSource), 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("b2b_back_to_fetch", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
